// File: rtl/ram_ctrl_pkg.sv
// Shared types for the RAM write-controller: FSM state encoding and requester ids.
package ram_ctrl_pkg;

    typedef enum logic {INIT, RUN} ramCtrlState_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/ram_1r1w_wr_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last-grant pointer.
module rr_arb2
    import ram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    logic last_grant_q;
    logic last_grant_d;

    // Bit 0 is requester A, bit 1 is requester B; on a tie the one not served last wins.
    always_comb begin
        gnt_o        = req_i;
        last_grant_d = last_grant_q;
        if (&req_i) begin
            gnt_o = (last_grant_q == REQ_A) ? 2'b10 : 2'b01;
        end
        if (advance_i && (|gnt_o)) begin
            last_grant_d = gnt_o[1] ? REQ_B : REQ_A;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= REQ_B;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/ram_1r1w_wr_ctrl.sv
// Write sequencer for a 1R1W async-read register RAM: initialization walk, then
// round-robin sharing of the write port between two requesters, with read bypass.
module ram_1r1w_wr_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned       DEPTH      = 64,
    parameter int unsigned       INDEX      = 6,
    parameter int unsigned       WIDTH      = 32,
    parameter logic [WIDTH-1:0]  INIT_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init_req_i,
    input  logic             wrA_valid_i,
    input  logic [INDEX-1:0] wrA_addr_i,
    input  logic [WIDTH-1:0] wrA_data_i,
    output logic             wrA_ready_o,
    input  logic             wrB_valid_i,
    input  logic [INDEX-1:0] wrB_addr_i,
    input  logic [WIDTH-1:0] wrB_data_i,
    output logic             wrB_ready_o,
    input  logic [INDEX-1:0] rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             rd_valid_o,
    output logic [INDEX-1:0] ram_addr0_o,
    input  logic [WIDTH-1:0] ram_data0_i,
    output logic             ram_we0_o,
    output logic [INDEX-1:0] ram_addr0wr_o,
    output logic [WIDTH-1:0] ram_data0wr_o,
    output logic             busy_o
);

    localparam logic [INDEX-1:0] LAST_IDX = INDEX'(DEPTH - 1);

    ramCtrlState_t    state_q;
    ramCtrlState_t    state_d;
    logic [INDEX-1:0] init_cnt_q;
    logic [INDEX-1:0] init_cnt_d;
    logic [1:0]       gnt;
    logic             arb_advance;

    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     ({wrB_valid_i, wrA_valid_i}),
        .advance_i (arb_advance),
        .gnt_o     (gnt)
    );

    // Next state and write-port mux; reset forces all outputs quiet for the cycle.
    always_comb begin
        state_d       = state_q;
        init_cnt_d    = init_cnt_q;
        arb_advance   = 1'b0;
        wrA_ready_o   = 1'b0;
        wrB_ready_o   = 1'b0;
        ram_we0_o     = 1'b0;
        ram_addr0wr_o = init_cnt_q;
        ram_data0wr_o = INIT_VALUE;
        busy_o        = 1'b1;
        rd_valid_o    = 1'b0;
        case (state_q)
            INIT: begin
                ram_we0_o = !reset;
                if (init_cnt_q == LAST_IDX) begin
                    state_d    = RUN;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + INDEX'(1);
                end
            end
            RUN: begin
                busy_o        = reset;
                rd_valid_o    = !reset;
                ram_addr0wr_o = gnt[1] ? wrB_addr_i : wrA_addr_i;
                ram_data0wr_o = gnt[1] ? wrB_data_i : wrA_data_i;
                if (init_req_i) begin
                    state_d    = INIT;
                    init_cnt_d = '0;
                end else if (!reset) begin
                    arb_advance = 1'b1;
                    wrA_ready_o = gnt[0];
                    wrB_ready_o = gnt[1];
                    ram_we0_o   = |gnt;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    assign ram_addr0_o = rd_addr_i;
    assign rd_data_o   = (ram_we0_o && (ram_addr0wr_o == rd_addr_i)) ? ram_data0wr_o : ram_data0_i;

    // Requester addresses beyond DEPTH are still written; flag them in simulation.
    a_wr_addr_in_range: assert property (@(posedge clk) disable iff (reset)
        (ram_we0_o && (state_q == RUN)) |-> (32'(ram_addr0wr_o) < DEPTH));

endmodule

// File: tb/tb_ram_1r1w_wr_ctrl.sv
// Self-checking bench for ram_1r1w_wr_ctrl: directed vectors, a per-cycle reference
// model of the write port / read path, and a second instance with DEPTH=48.
module tb_ram_1r1w_wr_ctrl;

    localparam int D1 = 64;
    localparam int D2 = 48;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        init_req_i = 1'b0;
    logic        wrA_valid_i = 1'b0;
    logic [5:0]  wrA_addr_i = '0;
    logic [31:0] wrA_data_i = '0;
    logic        wrA_ready_o;
    logic        wrB_valid_i = 1'b0;
    logic [5:0]  wrB_addr_i = '0;
    logic [31:0] wrB_data_i = '0;
    logic        wrB_ready_o;
    logic [5:0]  rd_addr_i = '0;
    logic [31:0] rd_data_o;
    logic        rd_valid_o;
    logic [5:0]  ram_addr0_o;
    logic [31:0] ram_data0_i;
    logic        ram_we0_o;
    logic [5:0]  ram_addr0wr_o;
    logic [31:0] ram_data0wr_o;
    logic        busy_o;

    logic        a2_ready, b2_ready, rv2, we2, busy2;
    logic [31:0] rd2, wd2;
    logic [5:0]  ra2, wa2;
    logic        zero1 = 1'b0;
    logic [5:0]  zero6 = '0;
    logic [31:0] zero32 = '0;

    int vectors = 0;
    int miscompares = 0;
    bit dut2_done = 1'b0;

    always #5 clk = ~clk;

    ram_1r1w_wr_ctrl #(.DEPTH(D1), .INDEX(6), .WIDTH(32)) dut (
        .clk(clk), .reset(reset), .init_req_i(init_req_i),
        .wrA_valid_i(wrA_valid_i), .wrA_addr_i(wrA_addr_i), .wrA_data_i(wrA_data_i), .wrA_ready_o(wrA_ready_o),
        .wrB_valid_i(wrB_valid_i), .wrB_addr_i(wrB_addr_i), .wrB_data_i(wrB_data_i), .wrB_ready_o(wrB_ready_o),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
        .ram_addr0_o(ram_addr0_o), .ram_data0_i(ram_data0_i), .ram_we0_o(ram_we0_o),
        .ram_addr0wr_o(ram_addr0wr_o), .ram_data0wr_o(ram_data0wr_o), .busy_o(busy_o)
    );

    ram_1r1w_wr_ctrl #(.DEPTH(D2), .INDEX(6), .WIDTH(32)) dut2 (
        .clk(clk), .reset(reset), .init_req_i(zero1),
        .wrA_valid_i(zero1), .wrA_addr_i(zero6), .wrA_data_i(zero32), .wrA_ready_o(a2_ready),
        .wrB_valid_i(zero1), .wrB_addr_i(zero6), .wrB_data_i(zero32), .wrB_ready_o(b2_ready),
        .rd_addr_i(zero6), .rd_data_o(rd2), .rd_valid_o(rv2),
        .ram_addr0_o(ra2), .ram_data0_i(zero32), .ram_we0_o(we2),
        .ram_addr0wr_o(wa2), .ram_data0wr_o(wd2), .busy_o(busy2)
    );

    // The RAM array itself: async read, write on the clock edge, no reset.
    logic [31:0] ram [D1];
    always @(posedge clk) if (ram_we0_o) ram[ram_addr0wr_o] <= ram_data0wr_o;
    assign ram_data0_i = ram[ram_addr0_o];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: remaining init writes, round-robin preference, expected contents.
    int          init_left = 0;
    bit          prefer_a = 1'b1;
    logic [31:0] ref_mem [D1];
    bit          known [D1];

    always @(negedge clk) begin
        logic        e_we, e_ra, e_rb, e_busy, e_rv, win_b;
        logic [5:0]  e_wa;
        logic [31:0] e_wd;
        e_we = 1'b0; e_ra = 1'b0; e_rb = 1'b0; e_wa = '0; e_wd = '0; win_b = 1'b0;
        if (reset) begin
            e_busy = 1'b1; e_rv = 1'b0;
        end else if (init_left > 0) begin
            e_busy = 1'b1; e_rv = 1'b0; e_we = 1'b1;
            e_wa = 6'(D1 - init_left); e_wd = 32'h0;
        end else begin
            e_busy = 1'b0; e_rv = 1'b1;
            if (!init_req_i && (wrA_valid_i || wrB_valid_i)) begin
                win_b = wrB_valid_i && (!wrA_valid_i || !prefer_a);
                e_we = 1'b1; e_ra = !win_b; e_rb = win_b;
                e_wa = win_b ? wrB_addr_i : wrA_addr_i;
                e_wd = win_b ? wrB_data_i : wrA_data_i;
            end
        end
        chk("model_we", 32'(ram_we0_o), 32'(e_we));
        chk("model_readyA", 32'(wrA_ready_o), 32'(e_ra));
        chk("model_readyB", 32'(wrB_ready_o), 32'(e_rb));
        chk("model_busy", 32'(busy_o), 32'(e_busy));
        chk("model_rd_valid", 32'(rd_valid_o), 32'(e_rv));
        chk("model_rd_addr", 32'(ram_addr0_o), 32'(rd_addr_i));
        if (e_we) begin
            chk("model_wr_addr", 32'(ram_addr0wr_o), 32'(e_wa));
            chk("model_wr_data", ram_data0wr_o, e_wd);
        end
        if (e_we && e_wa == rd_addr_i) chk("model_rd_bypass", rd_data_o, e_wd);
        else if (known[rd_addr_i]) chk("model_rd_data", rd_data_o, ref_mem[rd_addr_i]);

        if (reset) begin
            init_left = D1; prefer_a = 1'b1;
        end else if (init_left > 0) begin
            init_left--;
        end else if (init_req_i) begin
            init_left = D1;
        end else if (e_we) begin
            prefer_a = win_b;
        end
        if (e_we) begin
            ref_mem[e_wa] = e_wd;
            known[e_wa] = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts busy cycles from the next falling edge; may pulse init_req mid-walk.
    task automatic run_busy(input int pulse_at, output int n, output logic [5:0] fa);
        n = 0;
        fa = '1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!busy_o) break;
            if (n == 0) fa = ram_addr0wr_o;
            n++;
            @(posedge clk);
            #1;
            init_req_i = (n == pulse_at);
        end
    endtask

    // DEPTH=48 instance: 48 init writes ending at address 47, then RUN.
    initial begin
        int          n2;
        logic [5:0]  first2, last2;
        n2 = 0; first2 = '1; last2 = '1;
        @(negedge reset);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!busy2) break;
            if (n2 == 0) first2 = wa2;
            if (we2) last2 = wa2;
            n2++;
        end
        chk("d48_init_cycles", 32'(n2), 32'd48);
        chk("d48_first_addr", 32'(first2), 32'd0);
        chk("d48_last_addr", 32'(last2), 32'd47);
        chk("d48_rd_valid", 32'(rv2), 32'd1);
        dut2_done = 1'b1;
    end

    initial begin
        int         n;
        logic [5:0] fa;

        // Reset held: quiet write port, busy, no valid read.
        @(negedge clk);
        chk("rst_busy", 32'(busy_o), 32'd1);
        chk("rst_we", 32'(ram_we0_o), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid_o), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        run_busy(-1, n, fa);
        chk("init_cycles", 32'(n), 32'd64);
        chk("init_first_addr", 32'(fa), 32'd0);
        chk("run_rd_valid", 32'(rd_valid_o), 32'd1);
        tick();

        // Both requesters contend for four cycles: A first after reset, then alternate.
        wrA_valid_i = 1'b1; wrA_addr_i = 6'd1; wrA_data_i = 32'h11;
        wrB_valid_i = 1'b1; wrB_addr_i = 6'd2; wrB_data_i = 32'h22;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_grant", 32'({wrA_ready_o, wrB_ready_o}), (i % 2 == 0) ? 32'd2 : 32'd1);
            tick();
        end
        wrA_valid_i = 1'b0; wrB_valid_i = 1'b0;

        // Lone A write, zero-latency accept, readback next cycle.
        wrA_valid_i = 1'b1; wrA_addr_i = 6'd5; wrA_data_i = 32'hDEADBEEF; rd_addr_i = 6'd5;
        @(negedge clk);
        chk("a_alone_ready", 32'(wrA_ready_o), 32'd1);
        tick();
        wrA_valid_i = 1'b0;
        @(negedge clk);
        chk("a_readback", rd_data_o, 32'hDEADBEEF);
        tick();

        // Same-cycle bypass for B; old value visible before, new value after.
        rd_addr_i = 6'd9;
        @(negedge clk);
        chk("pre_bypass_old", rd_data_o, 32'h0);
        tick();
        wrB_valid_i = 1'b1; wrB_addr_i = 6'd9; wrB_data_i = 32'hCAFE;
        @(negedge clk);
        chk("b_ready", 32'(wrB_ready_o), 32'd1);
        chk("bypass_data", rd_data_o, 32'hCAFE);
        tick();
        wrB_valid_i = 1'b0;
        @(negedge clk);
        chk("post_bypass", rd_data_o, 32'hCAFE);
        tick();

        // Re-init request while A waits; a second request mid-walk must not extend it.
        wrA_valid_i = 1'b1; wrA_addr_i = 6'd3; wrA_data_i = 32'h33; init_req_i = 1'b1;
        @(negedge clk);
        chk("initreq_readyA", 32'(wrA_ready_o), 32'd0);
        chk("initreq_we", 32'(ram_we0_o), 32'd0);
        tick();
        init_req_i = 1'b0;
        run_busy(10, n, fa);
        chk("reinit_cycles", 32'(n), 32'd64);
        chk("reinit_first_addr", 32'(fa), 32'd0);
        chk("a_after_reinit", 32'(wrA_ready_o), 32'd1);
        tick();
        wrA_valid_i = 1'b0;
        rd_addr_i = 6'd5;
        @(negedge clk);
        chk("cleared_after_reinit", rd_data_o, 32'h0);

        // Reset in the middle of the walk restarts from address 0 for a full pass.
        tick();
        init_req_i = 1'b1;
        tick();
        init_req_i = 1'b0;
        repeat (30) tick();
        @(negedge clk);
        chk("walk_at_30", 32'(ram_addr0wr_o), 32'd30);
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        run_busy(-1, n, fa);
        chk("rst_mid_cycles", 32'(n), 32'd64);
        chk("rst_mid_first_addr", 32'(fa), 32'd0);
        tick();

        for (int k = 0; k < 200 && !dut2_done; k++) tick();
        if (!dut2_done) chk("d48_timeout", 32'd0, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_1r1w_wr_ctrl.md
Name: ram_1r1w_wr_ctrl

Overview:
- Sequencing and arbitration front-end for a single-read/single-write asynchronous-read register-array RAM. The RAM itself has no reset.
- After reset, or on request, the block walks every entry and writes INIT_VALUE. It then shares the one write port between two requesters using round-robin.
- Reads pass straight through to the RAM, with a same-cycle write-to-read bypass.
- Sits between pipeline-stage writers and the RAM instance, for example free-list or table storage.

Parameters:
- DEPTH, 64, number of RAM entries; need not be a power of two.
- INDEX, 6, address width; must satisfy 2^INDEX >= DEPTH.
- WIDTH, 32, data width.
- INIT_VALUE, {WIDTH{1'b0}}, value written to every entry during initialization.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- init_req_i  in  1  one-cycle pulse requesting re-initialization.
- wrA_valid_i  in  1  requester A has a write pending.
- wrA_addr_i  in  INDEX  requester A write address.
- wrA_data_i  in  WIDTH  requester A write data.
- wrA_ready_o  out  1  requester A write accepted this cycle.
- wrB_valid_i / wrB_addr_i / wrB_data_i / wrB_ready_o  same as A, for requester B.
- rd_addr_i  in  INDEX  read address.
- rd_data_o  out  WIDTH  read data, after bypass.
- rd_valid_o  out  1  read data is meaningful (not initializing).
- ram_addr0_o  out  INDEX  to RAM read address; equals rd_addr_i.
- ram_data0_i  in  WIDTH  from RAM read data.
- ram_we0_o  out  1  to RAM write enable.
- ram_addr0wr_o  out  INDEX  to RAM write address.
- ram_data0wr_o  out  WIDTH  to RAM write data.
- busy_o  out  1  initialization in progress.

Behaviour:
- FSM states: INIT and RUN. A registered counter init_cnt[INDEX-1:0] walks the entries. A registered last_grant bit records the last requester served.
- While reset=1 (sampled at the edge), the next state is:
  - state=INIT, init_cnt=0, last_grant=B, so A wins the first tie.
- Outputs while reset is asserted:
  - ram_we0_o=0.
  - wrA_ready_o=0 and wrB_ready_o=0.
  - busy_o=1, rd_valid_o=0.
- INIT:
  - Drives ram_we0_o=1, ram_addr0wr_o=init_cnt, ram_data0wr_o=INIT_VALUE.
  - Holds both ready outputs at 0.
  - init_cnt increments every cycle.
  - When init_cnt==DEPTH-1, the next state is RUN and init_cnt is set to 0.
  - Exactly DEPTH write cycles occur. The first cycle after reset deasserts writes address 0. busy_o falls in cycle DEPTH, counting from 0.
- init_req_i:
  - In RUN, the next state is INIT with init_cnt=0. No grant is issued in that cycle; both readies are 0.
  - In INIT, it is ignored; the walk is not restarted.
- RUN arbitration, combinational from the current valids and last_grant:
  - If only one requester is valid, it is granted.
  - If both are valid, the one not equal to last_grant is granted. last_grant updates only on a grant.
  - The granted requester's ready=1; the other's ready=0.
  - ram_we0_o=1 with the winner's address and data.
  - If neither is valid, ram_we0_o=0 and last_grant is held.
- Handshake rules:
  - A transfer occurs when valid&ready.
  - A requester must hold valid, addr and data stable until ready.
  - ready never depends on the requester's own addr or data.
- Arbitration latency: zero cycles. The RAM array updates at the same edge the handshake completes.
- Read path:
  - ram_addr0_o=rd_addr_i at all times.
  - If ram_we0_o && ram_addr0wr_o==rd_addr_i, then rd_data_o=ram_data0wr_o (bypass). Otherwise rd_data_o=ram_data0_i.
  - The bypass is also active in INIT.
  - rd_valid_o = (state==RUN).
- Addresses >= DEPTH from requesters: not checked, and the write is still issued. An assertion (simulation only) flags them.
- Reset mid-INIT or mid-RUN: the walk restarts from address 0 on the cycle after reset deasserts. No partial write state survives, because there are no pending registers.

Decomposition:
- Shared package ram_ctrl_pkg holds:
  - typedef enum logic {INIT, RUN} ramCtrlState_t.
  - Requester-id encoding: localparam REQ_A=1'b0, REQ_B=1'b1.
- One natural sub-module: rr_arb2 (2-way round-robin arbiter).
  - Inputs: clk, reset, req[1:0], advance.
  - Output: gnt[1:0].
  - Contains last_grant.
- FSM, counter, mux and bypass stay in the top module.

Test Plan:
- Reset, DEPTH=64 → exactly 64 consecutive writes of 0 to addresses 0..63. busy_o=1 for 64 cycles after reset deasserts, then 0. Ready stays 0 throughout.
- After init, A writes 0xDEADBEEF to addr 5 alone → wrA_ready_o=1 in the same cycle. The next-cycle read of addr 5 returns 0xDEADBEEF.
- Both valid for 4 consecutive cycles (A: addr 1/data 0x11, B: addr 2/data 0x22, each re-presented after acceptance) → grants A,B,A,B. Each requester is never stalled more than 1 cycle.
- B writes 0xCAFE to addr 9 while rd_addr_i=9 in the same cycle → rd_data_o=0xCAFE that cycle (bypass). Without the write, the old value is returned.
- Pulse init_req_i in RUN with A valid → wrA_ready_o=0 that cycle. The 64-entry clear is re-run, and A is accepted on the first RUN cycle afterwards. A pulse during INIT does not extend busy_o.
- Assert reset at init_cnt=30 → after deassert the walk restarts at address 0 and still lasts exactly DEPTH cycles. Also run with DEPTH=48, INDEX=6: the last init address is 47, then RUN.
